// File: rtl/pool_stream_buffer_if.sv
// Handshake bundle around pool_stream_buffer: pooled words in from the pooling
// layer, show-ahead words out to the next layer over valid/ready.
interface pool_stream_buffer_if #(
  parameter int D_WIDTH  = 8,
  parameter int CHANNELS = 4
);
  logic [D_WIDTH*CHANNELS-1:0] input_data;
  logic                        input_valid;
  logic [D_WIDTH*CHANNELS-1:0] output_data;
  logic                        output_valid;
  logic                        output_ready;
  logic                        frame_last;

  modport slave (
    input  input_data, input_valid, output_ready,
    output output_data, output_valid, frame_last
  );

  modport master (
    output input_data, input_valid, output_ready,
    input  output_data, output_valid, frame_last
  );
endinterface

// File: rtl/pool_stream_buffer.sv
// Show-ahead FIFO after the pooling layer; tags the last word of every frame.
// Optional macro POOL_BUF_RELU_EN clamps negative samples to zero on write.
module pool_stream_buffer #(
  parameter int D_WIDTH  = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int OUT_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  pool_stream_buffer_if.slave      bus,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int W     = D_WIDTH * CHANNELS;
  localparam int AW    = $clog2(DEPTH);
  localparam int FRAME = OUT_SIZE * OUT_SIZE;
  localparam int PW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PIX = PW'(FRAME - 1);

  // Bit W of each entry carries the frame-last tag.
  logic [W:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [PW-1:0] r_pix_cnt;

  logic          w_wr;
  logic          w_rd;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_last;
  logic [W-1:0]  w_data_in;
  logic [W:0]    w_head;

  assign w_wr    = clk_en & bus.input_valid;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_rd    = ~w_empty & bus.output_ready;
  assign w_push  = w_wr & (~w_full | w_rd);
  assign w_last  = (r_pix_cnt == LAST_PIX);

  always_comb begin
    w_data_in = bus.input_data;
`ifdef POOL_BUF_RELU_EN
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.input_data[D_WIDTH*c + D_WIDTH-1]) begin
        w_data_in[D_WIDTH*c +: D_WIDTH] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_last, w_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_pix_cnt  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_rd)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_rd) r_count <= r_count - (AW+1)'(1);
      if (w_wr && w_full && !w_rd) r_overflow <= 1'b1;
      // Frame position advances on every write, even when the word is dropped.
      if (w_wr) r_pix_cnt <= w_last ? '0 : r_pix_cnt + PW'(1);
    end
  end

  assign w_head           = r_mem[r_rd_ptr];
  assign bus.output_valid = ~w_empty;
  assign bus.output_data  = w_empty ? '0 : w_head[W-1:0];
  assign bus.frame_last   = w_empty ? 1'b0 : w_head[W];
  assign overflow         = r_overflow;
  assign count            = r_count;
endmodule

// File: tb/tb_pool_stream_buffer.sv
// Bench for pool_stream_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pool_stream_buffer;
  localparam int D_WIDTH  = 8;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 16;
  localparam int OUT_SIZE = 4;
  localparam int W        = D_WIDTH * CHANNELS;
  localparam int FRAME    = OUT_SIZE * OUT_SIZE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_en = 1'b0;
  logic       overflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [W:0] q[$];
  int         pix = 0;
  bit         m_ovf = 1'b0;

  pool_stream_buffer_if #(.D_WIDTH(D_WIDTH), .CHANNELS(CHANNELS)) bus ();

  pool_stream_buffer #(
    .D_WIDTH(D_WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .OUT_SIZE(OUT_SIZE)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .bus(bus),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
`ifdef POOL_BUF_RELU_EN
    for (int c = 0; c < CHANNELS; c++) begin
      if ($signed(d[D_WIDTH*c +: D_WIDTH]) < 0) r[D_WIDTH*c +: D_WIDTH] = '0;
    end
`endif
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic wr, input logic [W-1:0] d, input logic rdy);
    bit full;
    bit rd;
    if (rst) begin
      q.delete();
      pix   = 0;
      m_ovf = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    rd   = (q.size() != 0) && rdy;
    if (rd) void'(q.pop_front());
    if (wr) begin
      if (!full || rd) q.push_back({(pix == FRAME - 1), relu(d)});
      else m_ovf = 1'b1;
      pix = (pix + 1) % FRAME;
    end
  endtask

  task automatic cycle(input logic rst, input logic en, input logic vld,
                       input logic [W-1:0] d, input logic rdy);
    @(negedge clk);
    #1;
    reset            = rst;
    clk_en           = en;
    bus.input_valid  = vld;
    bus.input_data   = d;
    bus.output_ready = rdy;
    model_step(rst, en & vld, d, rdy);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Model comparison on every falling edge, half a cycle after each update.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W:0] head;
      bit         v;
      v    = (q.size() != 0);
      head = v ? q[0] : '0;
      check("model_valid", 64'(bus.output_valid), 64'(v));
      check("model_data", 64'(bus.output_data), 64'(head[W-1:0]));
      check("model_last", 64'(bus.frame_last), 64'(head[W]));
      check("model_count", 64'(count), 64'(q.size()));
      check("model_overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  initial begin
    logic         r_rst, r_en, r_vld, r_rdy;
    logic [W-1:0] r_d;
    logic [W-1:0] hd;

    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b0;

    // Reset then idle
    cycle(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    cycle(0, 0, 0, 0, 0);
    settle();
    check("rst_valid", 64'(bus.output_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_data", 64'(bus.output_data), 64'd0);

    // One full frame streamed straight through, plus first word of next frame
    for (int k = 1; k <= 17; k++) begin
      cycle(0, 1, 1, W'(k), 1);
      settle();
      check("stream_data", 64'(bus.output_data), 64'(k));
      check("stream_last", 64'(bus.frame_last), 64'(k == 16));
    end
    cycle(0, 1, 0, 0, 1);
    settle();
    check("stream_drained", 64'(bus.output_valid), 64'd0);

    // Fill with ready low, overflow on the 17th
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      cycle(0, 1, 1, W'(k), 0);
      settle();
      if (k == 16) begin
        check("fill_count16", 64'(count), 64'd16);
        check("fill_no_ovf", 64'(overflow), 64'd0);
      end
    end
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_set", 64'(overflow), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      check("ovf_drain", 64'(bus.output_data), 64'(k));
      cycle(0, 1, 0, 0, 1);
      settle();
    end
    check("ovf_empty", 64'(bus.output_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous write and read
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) cycle(0, 1, 1, W'(k), 0);
    cycle(0, 1, 1, W'('h55), 1);
    settle();
    check("fullrw_count", 64'(count), 64'd16);
    check("fullrw_ovf", 64'(overflow), 64'd0);
    for (int k = 2; k <= 16; k++) begin
      check("fullrw_drain", 64'(bus.output_data), 64'(k));
      cycle(0, 1, 0, 0, 1);
      settle();
    end
    check("fullrw_tail", 64'(bus.output_data), 64'h55);

    // clk_en low blocks writes but not reads; frame position held
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) cycle(0, 1, 1, W'(k), 0);
    for (int j = 0; j < 5; j++) begin
      cycle(0, 0, 1, W'('hAA), 1);
      settle();
      check("clken_count", 64'(count), 64'((j < 3) ? 2 - j : 0));
    end
    for (int k = 1; k <= 13; k++) begin
      cycle(0, 1, 1, W'(k + 'h20), 1);
      settle();
      check("clken_last", 64'(bus.frame_last), 64'(k == 13));
    end

    // Negative sample handling
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, W'('h0000_05F0), 0);
    settle();
    hd = bus.output_data;
`ifdef POOL_BUF_RELU_EN
    check("relu_ch0", 64'(hd[7:0]), 64'h00);
`else
    check("relu_ch0", 64'(hd[7:0]), 64'hF0);
`endif
    check("relu_ch1", 64'(hd[15:8]), 64'h05);

    // Reset with words stored discards them and the partial frame
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) cycle(0, 1, 1, W'(k), 0);
    cycle(1, 0, 0, 0, 0);
    settle();
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_valid", 64'(bus.output_valid), 64'd0);
    for (int k = 1; k <= 16; k++) begin
      cycle(0, 1, 1, W'(k), 1);
      settle();
      check("midrst_last", 64'(bus.frame_last), 64'(k == 16));
    end

    // Random traffic, alternating drain-heavy and fill-heavy phases
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_en  = ($urandom_range(0, 9) < 8);
      r_vld = ($urandom_range(0, 3) != 0);
      r_rdy = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r_d   = W'($urandom());
      cycle(r_rst, r_en, r_vld, r_d, r_rdy);
    end
    cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
